// File: rtl/vector_packer_pkg.sv
// Shared types and width helpers for the vector_packer streaming bit-field concatenator.
package vector_packer_pkg;

   typedef enum logic [1:0] {
      S_ACC   = 2'd0,
      S_FULL  = 2'd1,
      S_FLUSH = 2'd2
   } state_t;

   // Bits needed to express a field length of 0..inW.
   function automatic int lenWidth(input int inW);
      return $clog2(inW + 1);
   endfunction

   // Bits needed to count the accumulator fill, 0..outW+inW.
   function automatic int fillWidth(input int inW, input int outW);
      return $clog2(outW + inW + 1);
   endfunction

endpackage

// File: rtl/vector_field_mask.sv
// Clamps a field length to IN_W and zeroes every data bit at or above that length.
module vector_field_mask
   import vector_packer_pkg::*;
#(
   parameter  int IN_W  = 8,
   localparam int LEN_W = lenWidth(IN_W)
) (
   input  logic [IN_W-1:0]  i_data,
   input  logic [LEN_W-1:0] i_len,
   output logic [IN_W-1:0]  o_data,
   output logic [LEN_W-1:0] o_len
);

   always_comb begin
      o_len = (i_len > LEN_W'(IN_W)) ? LEN_W'(IN_W) : i_len;
      for (int i = 0; i < IN_W; i++) begin
         o_data[i] = i_data[i] & (LEN_W'(i) < o_len);
      end
   end

endmodule

// File: rtl/vector_packer.sv
// Packs variable-width fields back-to-back into OUT_W-bit words with valid/ready on both sides.
// Define VECTOR_PACKER_MSB_FIRST_EN for MSB-first packing (first field in the top bits).
module vector_packer
   import vector_packer_pkg::*;
#(
   parameter  int IN_W   = 8,
   parameter  int OUT_W  = 16,
   localparam int LEN_W  = lenWidth(IN_W),
   localparam int FILL_W = fillWidth(IN_W, OUT_W)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [IN_W-1:0]   in_data,
   input  logic [LEN_W-1:0]  in_len,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  out_data,
   output logic [FILL_W-1:0] out_bits
);

   localparam int ACC_W = OUT_W + IN_W;

   generate
      if (OUT_W < IN_W) begin : g_widthCheck
         $error("vector_packer: OUT_W (%0d) must be >= IN_W (%0d)", OUT_W, IN_W);
      end
   endgenerate

   state_t             r_state;
   state_t             w_stateNext;
   logic [ACC_W-1:0]   r_acc;
   logic [ACC_W-1:0]   w_accNext;
   logic [FILL_W-1:0]  r_fill;
   logic [FILL_W-1:0]  w_fillNext;
   logic               r_lastPend;
   logic               w_lastPendNext;

   logic [IN_W-1:0]    w_field;
   logic [LEN_W-1:0]   w_len;
   logic [ACC_W-1:0]   w_fieldExt;
   logic [ACC_W-1:0]   w_fieldPlaced;
   logic [ACC_W-1:0]   w_accDrained;
   logic [OUT_W-1:0]   w_word;
   logic [FILL_W-1:0]  w_fillSum;
   logic               w_inFire;
   logic               w_outFire;

   vector_field_mask #(.IN_W(IN_W)) u_mask (
      .i_data (in_data),
      .i_len  (in_len),
      .o_data (w_field),
      .o_len  (w_len)
   );

   assign w_fieldExt = {{OUT_W{1'b0}}, w_field};
   assign w_fillSum  = r_fill + FILL_W'(w_len);

`ifdef VECTOR_PACKER_MSB_FIRST_EN
   // The accumulator is left-justified: the oldest bit sits at ACC_W-1.
   assign w_fieldPlaced = w_fieldExt << (FILL_W'(ACC_W) - w_fillSum);
   assign w_accDrained  = r_acc << OUT_W;
   assign w_word        = r_acc[ACC_W-1 -: OUT_W];
`else
   assign w_fieldPlaced = w_fieldExt << r_fill;
   assign w_accDrained  = r_acc >> OUT_W;
   assign w_word        = r_acc[OUT_W-1:0];
`endif

   assign in_ready  = (r_state == S_ACC);
   assign out_valid = (r_state != S_ACC);
   assign w_inFire  = in_valid & in_ready;
   assign w_outFire = out_valid & out_ready;
   assign out_data  = out_valid ? w_word : '0;

   always_comb begin
      out_bits = '0;
      case (r_state)
         S_FULL:  out_bits = FILL_W'(OUT_W);
         S_FLUSH: out_bits = r_fill;
         default: out_bits = '0;
      endcase
   end

   always_comb begin
      w_stateNext    = r_state;
      w_accNext      = r_acc;
      w_fillNext     = r_fill;
      w_lastPendNext = r_lastPend;
      case (r_state)
         S_ACC: begin
            if (w_inFire) begin
               w_accNext  = r_acc | w_fieldPlaced;
               w_fillNext = w_fillSum;
               if (w_fillSum >= FILL_W'(OUT_W)) begin
                  w_stateNext    = S_FULL;
                  w_lastPendNext = in_last;
               end else if (in_last && (w_fillSum != '0)) begin
                  w_stateNext = S_FLUSH;
               end
            end
         end
         S_FULL: begin
            if (w_outFire) begin
               w_accNext      = w_accDrained;
               w_fillNext     = r_fill - FILL_W'(OUT_W);
               w_lastPendNext = 1'b0;
               w_stateNext    = (r_lastPend && (w_fillNext != '0)) ? S_FLUSH : S_ACC;
            end
         end
         S_FLUSH: begin
            if (w_outFire) begin
               w_accNext   = '0;
               w_fillNext  = '0;
               w_stateNext = S_ACC;
            end
         end
         default: begin
            w_stateNext    = S_ACC;
            w_accNext      = '0;
            w_fillNext     = '0;
            w_lastPendNext = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_ACC;
         r_acc      <= '0;
         r_fill     <= '0;
         r_lastPend <= 1'b0;
      end else begin
         r_state    <= w_stateNext;
         r_acc      <= w_accNext;
         r_fill     <= w_fillNext;
         r_lastPend <= w_lastPendNext;
      end
   end

endmodule

// File: tb/tb_vector_packer.sv
// Self-checking bench for vector_packer (IN_W=8, OUT_W=16): directed table, corner sequences, random vs bit-queue model.
module tb_vector_packer;

`ifdef VECTOR_PACKER_MSB_FIRST_EN
   localparam bit MSB_FIRST = 1'b1;
`else
   localparam bit MSB_FIRST = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic [3:0]  in_len;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic [4:0]  out_bits;

   typedef struct packed {
      logic [15:0] data;
      logic [4:0]  bits;
   } word_t;

   typedef struct {
      logic [7:0]  data;
      logic [3:0]  len;
      logic        last;
      logic        expOut;
      logic [15:0] expData;
      logic [4:0]  expBits;
   } vec_t;

   int    nVec;
   int    nMiss;
   bit    useModel;
   word_t expQ[$];
   bit    bitQ[$];
   vec_t  vecs[12];

   vector_packer #(.IN_W(8), .OUT_W(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_len    (in_len),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_bits  (out_bits)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkEq(input string name, input logic [31:0] got, input logic [31:0] exp);
      nVec++;
      if (got !== exp) begin
         nMiss++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   // Builds one expected word from the oldest n bits of the reference bit stream.
   task automatic emitWord(input int n);
      logic [15:0] w;
      w = '0;
      for (int k = 0; k < n; k++) begin
         if (MSB_FIRST) w[15-k] = bitQ.pop_front();
         else           w[k]    = bitQ.pop_front();
      end
      expQ.push_back({w, 5'(n)});
   endtask

   task automatic modelAccept(input logic [7:0] d, input logic [3:0] l, input logic lst);
      int lc;
      lc = (l > 4'd8) ? 8 : int'(l);
      if (MSB_FIRST) begin
         for (int b = lc - 1; b >= 0; b--) bitQ.push_back(d[b]);
      end else begin
         for (int b = 0; b < lc; b++) bitQ.push_back(d[b]);
      end
      while (bitQ.size() >= 16) emitWord(16);
      if (lst && bitQ.size() > 0) emitWord(bitQ.size());
   endtask

   task automatic checkOutput();
      word_t e;
      if (expQ.size() == 0) begin
         nVec++;
         nMiss++;
         $display("[TB] FAIL unexpectedWord: got 0x%0h/%0d, expected no word", out_data, out_bits);
      end else begin
         e = expQ.pop_front();
         checkEq("wordData", 32'(out_data), 32'(e.data));
         checkEq("wordBits", 32'(out_bits), 32'(e.bits));
      end
   endtask

   // Called at a negedge: drives one cycle of inputs, scores the transfers at the coming posedge.
   task automatic applyStimulus(input logic v, input logic [7:0] d, input logic [3:0] l,
                                input logic lst, input logic ordy, output logic accepted);
      in_valid  = v;
      in_data   = d;
      in_len    = l;
      in_last   = lst;
      out_ready = ordy;
      accepted  = v && in_ready;
      if (out_valid && ordy) checkOutput();
      if (accepted && useModel) modelAccept(d, l, lst);
      @(negedge clk);
   endtask

   task automatic sendField(input logic [7:0] d, input logic [3:0] l, input logic lst, input logic ordy);
      logic acc;
      acc = 1'b0;
      for (int c = 0; c < 30 && !acc; c++) applyStimulus(1'b1, d, l, lst, ordy, acc);
      if (!acc) begin
         nVec++;
         nMiss++;
         $display("[TB] FAIL sendTimeout: field 0x%0h not accepted, in_ready=%0b", d, in_ready);
      end
   endtask

   task automatic idle(input int n);
      logic acc;
      for (int c = 0; c < n; c++) applyStimulus(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, acc);
   endtask

   initial begin
      logic acc;
      nVec      = 0;
      nMiss     = 0;
      useModel  = 1'b0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_len    = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;

      vecs[0]  = '{8'h0A, 4'd4,  1'b0, 1'b0, 16'h0000, 5'd0};
      vecs[1]  = '{8'h0B, 4'd4,  1'b0, 1'b0, 16'h0000, 5'd0};
      vecs[2]  = '{8'hCD, 4'd8,  1'b0, 1'b1, MSB_FIRST ? 16'hABCD : 16'hCDBA, 5'd16};
      vecs[3]  = '{8'h34, 4'd8,  1'b0, 1'b0, 16'h0000, 5'd0};
      vecs[4]  = '{8'h02, 4'd4,  1'b0, 1'b0, 16'h0000, 5'd0};
      vecs[5]  = '{8'hFF, 4'd8,  1'b0, 1'b1, MSB_FIRST ? 16'h342F : 16'hF234, 5'd16};
      vecs[6]  = '{8'h00, 4'd0,  1'b1, 1'b1, MSB_FIRST ? 16'hF000 : 16'h000F, 5'd4};
      vecs[7]  = '{8'h11, 4'd8,  1'b0, 1'b0, 16'h0000, 5'd0};
      vecs[8]  = '{8'h22, 4'd8,  1'b1, 1'b1, MSB_FIRST ? 16'h1122 : 16'h2211, 5'd16};
      vecs[9]  = '{8'h3C, 4'd12, 1'b0, 1'b0, 16'h0000, 5'd0};
      vecs[10] = '{8'hF1, 4'd8,  1'b0, 1'b1, MSB_FIRST ? 16'h3CF1 : 16'hF13C, 5'd16};
      vecs[11] = '{8'hFF, 4'd3,  1'b1, 1'b1, MSB_FIRST ? 16'hE000 : 16'h0007, 5'd3};

      @(negedge clk);
      @(negedge clk);
      checkEq("rstOutValid", 32'(out_valid), 32'd0);
      checkEq("rstOutData",  32'(out_data),  32'd0);
      checkEq("rstOutBits",  32'(out_bits),  32'd0);
      checkEq("rstInReady",  32'(in_ready),  32'd1);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] directed table");
      for (int i = 0; i < 12; i++) begin
         if (vecs[i].expOut) expQ.push_back({vecs[i].expData, vecs[i].expBits});
         sendField(vecs[i].data, vecs[i].len, vecs[i].last, 1'b1);
      end
      idle(4);
      checkEq("tableDrained", 32'(expQ.size()), 32'd0);
      checkEq("tableIdle", 32'(out_valid), 32'd0);

      $display("[TB] backpressure hold");
      expQ.push_back({MSB_FIRST ? 16'h1122 : 16'h2211, 5'd16});
      sendField(8'h11, 4'd8, 1'b0, 1'b0);
      sendField(8'h22, 4'd8, 1'b0, 1'b0);
      for (int c = 0; c < 5; c++) begin
         checkEq("holdValid", 32'(out_valid), 32'd1);
         checkEq("holdData",  32'(out_data),  32'(MSB_FIRST ? 16'h1122 : 16'h2211));
         checkEq("holdBits",  32'(out_bits),  32'd16);
         checkEq("holdReady", 32'(in_ready),  32'd0);
         applyStimulus(1'b1, 8'h77, 4'd8, 1'b0, 1'b0, acc);
         checkEq("holdNoAccept", 32'(acc), 32'd0);
      end
      sendField(8'h77, 4'd8, 1'b0, 1'b1);
      expQ.push_back({MSB_FIRST ? 16'h7788 : 16'h8877, 5'd16});
      sendField(8'h88, 4'd8, 1'b0, 1'b1);
      idle(4);
      checkEq("holdDrained", 32'(expQ.size()), 32'd0);

      $display("[TB] reset during flush");
      sendField(8'h0F, 4'd4, 1'b1, 1'b0);
      checkEq("flushPending", 32'(out_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      checkEq("asyncOutValid", 32'(out_valid), 32'd0);
      checkEq("asyncOutData",  32'(out_data),  32'd0);
      checkEq("asyncOutBits",  32'(out_bits),  32'd0);
      checkEq("asyncInReady",  32'(in_ready),  32'd1);
      in_valid = 1'b0;
      #1 rst_n = 1'b1;
      @(negedge clk);
      expQ.push_back({MSB_FIRST ? 16'h5AA5 : 16'hA55A, 5'd16});
      sendField(8'h5A, 4'd8, 1'b0, 1'b1);
      sendField(8'hA5, 4'd8, 1'b0, 1'b1);
      idle(4);
      checkEq("postRstDrained", 32'(expQ.size()), 32'd0);

      $display("[TB] random traffic");
      useModel = 1'b1;
      for (int c = 0; c < 600; c++) begin
         applyStimulus(($urandom_range(0, 3) != 0), 8'($urandom), 4'($urandom_range(0, 10)),
                       ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0), acc);
      end
      // Close the stream so every buffered bit must come out.
      sendField(8'h00, 4'd0, 1'b1, 1'b1);
      for (int c = 0; c < 40 && expQ.size() > 0; c++) idle(1);
      checkEq("randomDrained", 32'(expQ.size()), 32'd0);
      checkEq("randomIdle", 32'(out_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
      $finish;
   end

endmodule
